// File: rtl/regfile_pkg.sv
// Shared types, default sizes and write-port arbitration for the multi-port register file.
package regfile_pkg;

  localparam int unsigned DefDataW   = 32;
  localparam int unsigned DefAddrW   = 5;
  localparam int unsigned DefNumRd   = 2;
  localparam int unsigned DefNumWr   = 2;
  localparam int unsigned DefCntW    = 2;
  localparam int unsigned MaxWrPorts = 8;
  localparam int unsigned PortIdxW   = $clog2(MaxWrPorts);

  typedef enum logic [1:0] {StIdle, StClear, StDone} clr_state_e;

  typedef struct packed {
    logic                valid;
    logic [PortIdxW-1:0] port;
  } wr_win_t;

  // hit[p] = port p writes the address in question; the highest set index wins.
  function automatic wr_win_t find_winner(input logic [MaxWrPorts-1:0] hit);
    wr_win_t w;
    w = '0;
    for (int p = 0; p < MaxWrPorts; p++) begin
      if (hit[p]) begin
        w.valid = 1'b1;
        w.port  = PortIdxW'(p);
      end
    end
    return w;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending-write counters: issue increments, committed write decrements.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned ADDR_W = DefAddrW,
  parameter int unsigned NUM_RD = DefNumRd,
  parameter int unsigned CNT_W  = DefCntW
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     idle_i,
  input  logic                     issue_valid_i,
  input  logic [ADDR_W-1:0]        issue_addr_i,
  input  logic [2**ADDR_W-1:0]     wr_commit_i,
  input  logic                     clr_en_i,
  input  logic [ADDR_W-1:0]        clr_idx_i,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr_i,
  output logic [NUM_RD-1:0]        rd_busy_o,
  output logic                     issue_ready_o
);

  localparam int unsigned      RegNum = 2**ADDR_W;
  localparam logic [CNT_W-1:0] CntMax = '1;

  logic [CNT_W-1:0] cnt_q [RegNum];
  logic [CNT_W-1:0] cnt_d [RegNum];
  logic             issue_acc;

  assign issue_ready_o = idle_i && (cnt_q[issue_addr_i] != CntMax);
  assign issue_acc     = issue_valid_i && issue_ready_o;

  // Register 0 is never counted, so its counter holds the reset value forever.
  always_comb begin
    for (int r = 0; r < RegNum; r++) begin
      cnt_d[r] = cnt_q[r];
      if (r != 0) begin
        if (clr_en_i && (clr_idx_i == ADDR_W'(r))) begin
          cnt_d[r] = '0;
        end else if (issue_acc && (issue_addr_i == ADDR_W'(r)) && !wr_commit_i[r]) begin
          cnt_d[r] = cnt_q[r] + CNT_W'(1);
        end else if (wr_commit_i[r] && !(issue_acc && (issue_addr_i == ADDR_W'(r)))
                     && (cnt_q[r] != '0)) begin
          cnt_d[r] = cnt_q[r] - CNT_W'(1);
        end
      end
    end
  end

  always_comb begin
    rd_busy_o = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      rd_busy_o[i] = (cnt_q[rd_addr_i[i*ADDR_W +: ADDR_W]] != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < RegNum; r++) begin
        cnt_q[r] <= '0;
      end
    end else begin
      for (int r = 0; r < RegNum; r++) begin
        cnt_q[r] <= cnt_d[r];
      end
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with write bypass, pending-write scoreboard and soft-clear sweep.
// Define REGFILE_TRACE_EN to print a line for every committed write.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W = DefDataW,
  parameter int unsigned ADDR_W = DefAddrW,
  parameter int unsigned NUM_RD = DefNumRd,
  parameter int unsigned NUM_WR = DefNumWr,
  parameter int unsigned CNT_W  = DefCntW
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] wr_data,
  input  logic [NUM_WR*32-1:0]     wr_pc,
  input  logic                     issue_valid,
  input  logic [ADDR_W-1:0]        issue_addr,
  output logic                     issue_ready,
  input  logic                     clear_req,
  output logic                     clear_busy,
  output logic                     clear_done
);

  localparam int unsigned       RegNum  = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(RegNum - 1);

  clr_state_e        state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [DATA_W-1:0] regs_q [RegNum];
  logic [DATA_W-1:0] regs_d [RegNum];
  wr_win_t           win [RegNum];
  logic [RegNum-1:0] wr_commit;
  logic              idle;

  assign idle = (state_q == StIdle);

  function automatic logic [MaxWrPorts-1:0] port_hits(input logic [NUM_WR-1:0]        en,
                                                      input logic [NUM_WR*ADDR_W-1:0] addrs,
                                                      input logic [ADDR_W-1:0]        a);
    logic [MaxWrPorts-1:0] h;
    h = '0;
    for (int p = 0; p < NUM_WR; p++) begin
      h[p] = en[p] && (addrs[p*ADDR_W +: ADDR_W] == a) && (a != '0);
    end
    return h;
  endfunction

  // Writes only land while idle; the sweep owns the array otherwise.
  always_comb begin
    wr_commit = '0;
    for (int r = 0; r < RegNum; r++) begin
      win[r]       = find_winner(port_hits(wr_en, wr_addr, ADDR_W'(r)));
      wr_commit[r] = idle && win[r].valid;
    end
  end

  always_comb begin
    for (int r = 0; r < RegNum; r++) begin
      regs_d[r] = regs_q[r];
      if ((r != 0) && wr_commit[r]) begin
        regs_d[r] = wr_data[int'(win[r].port)*DATA_W +: DATA_W];
      end
    end
    if (state_q == StClear) begin
      regs_d[idx_q] = '0;
    end
  end

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      rd_data[i*DATA_W +: DATA_W] = regs_q[rd_addr[i*ADDR_W +: ADDR_W]];
      if (idle && win[rd_addr[i*ADDR_W +: ADDR_W]].valid) begin
        rd_data[i*DATA_W +: DATA_W] =
            wr_data[int'(win[rd_addr[i*ADDR_W +: ADDR_W]].port)*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    clear_busy = 1'b0;
    clear_done = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (clear_req) begin
          state_d = StClear;
          idx_d   = ADDR_W'(1);
        end
      end
      StClear: begin
        clear_busy = 1'b1;
        idx_d      = idx_q + ADDR_W'(1);
        if (idx_q == LastIdx) begin
          state_d = StDone;
        end
      end
      StDone: begin
        clear_done = 1'b1;
        state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      idx_q   <= ADDR_W'(1);
      for (int r = 0; r < RegNum; r++) begin
        regs_q[r] <= '0;
      end
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      for (int r = 0; r < RegNum; r++) begin
        regs_q[r] <= regs_d[r];
      end
    end
  end

  regfile_scoreboard #(
    .ADDR_W (ADDR_W),
    .NUM_RD (NUM_RD),
    .CNT_W  (CNT_W)
  ) u_scoreboard (
    .clk           (clk),
    .reset         (reset),
    .idle_i        (idle),
    .issue_valid_i (issue_valid),
    .issue_addr_i  (issue_addr),
    .wr_commit_i   (wr_commit),
    .clr_en_i      (state_q == StClear),
    .clr_idx_i     (idx_q),
    .rd_addr_i     (rd_addr),
    .rd_busy_o     (rd_busy),
    .issue_ready_o (issue_ready)
  );

`ifdef REGFILE_TRACE_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int r = 1; r < RegNum; r++) begin
        if (wr_commit[r]) begin
          $display("%d@%h: $%d <= %h", $time, wr_pc[int'(win[r].port)*32 +: 32],
                   ADDR_W'(r), wr_data[int'(win[r].port)*DATA_W +: DATA_W]);
        end
      end
    end
  end
`else
  logic unused_wr_pc;
  assign unused_wr_pc = ^wr_pc;
`endif

endmodule
